// File: rtl/hit_resolver_if.sv
// Player-side bundle for hit_resolver: FSM states, positions and attack kinds in;
// pulses, stun flags, life counters and game result out.
interface hit_resolver_if #(
  parameter int X_W    = 10,
  parameter int ST_W   = 4,
  parameter int LIFE_W = 2,
  parameter int LIVES  = 3
);
  logic [ST_W-1:0]   state_1;
  logic [ST_W-1:0]   state_2;
  logic [X_W-1:0]    p1_x;
  logic [X_W-1:0]    p2_x;
  logic              attacking1;
  logic              dir_attacking1;
  logic              attacking2;
  logic              dir_attacking2;
  logic              hit1_pulse;
  logic              hit2_pulse;
  logic              block1_pulse;
  logic              block2_pulse;
  logic              stun1_flag;
  logic              stun2_flag;
  logic [LIFE_W-1:0] lives1;
  logic [LIFE_W-1:0] lives2;
  logic [LIVES-1:0]  life_leds1;
  logic [LIVES-1:0]  life_leds2;
  logic              game_over;
  logic [1:0]        winner;

  modport master (
    output state_1, state_2, p1_x, p2_x,
           attacking1, dir_attacking1, attacking2, dir_attacking2,
    input  hit1_pulse, hit2_pulse, block1_pulse, block2_pulse,
           stun1_flag, stun2_flag, lives1, lives2,
           life_leds1, life_leds2, game_over, winner
  );

  modport slave (
    input  state_1, state_2, p1_x, p2_x,
           attacking1, dir_attacking1, attacking2, dir_attacking2,
    output hit1_pulse, hit2_pulse, block1_pulse, block2_pulse,
           stun1_flag, stun2_flag, lives1, lives2,
           life_leds1, life_leds2, game_over, winner
  );
endinterface

// File: rtl/hit_resolver.sv
// Two-player hit resolution: one resolution per attack, blocking, stun, lives, game-over.
// All outputs registered; results appear one clock after the resolving cycle.
module hit_resolver #(
  parameter int X_W          = 10,
  parameter int ST_W         = 4,
  parameter int SPRITE_W     = 64,
  parameter int HIT_W_BASIC  = 32,
  parameter int HIT_W_DIR    = 20,
  parameter int S_ATTACK_ACT = 6,
  parameter int S_MOVE_BWD   = 2,
  parameter int LIVES        = 3,
  parameter int LIFE_W       = 2,
  parameter int STUN_CYCLES  = 30,
  parameter int BLOCK_EN     = 1
) (
  input logic          clk,
  input logic          reset,
  hit_resolver_if.slave bus
);

  localparam int RW     = X_W + 2;
  localparam int STUN_W = $clog2(STUN_CYCLES + 1);

  localparam logic [ST_W-1:0]   ST_ACT     = ST_W'(S_ATTACK_ACT);
  localparam logic [ST_W-1:0]   ST_BWD     = ST_W'(S_MOVE_BWD);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
  localparam logic [STUN_W-1:0] STUN_LOAD  = STUN_W'(STUN_CYCLES);

  typedef enum logic {PLAY, OVER} phase_t;

  phase_t            phase;
  logic              latch1, latch2;
  logic [STUN_W-1:0] stun1_cnt, stun2_cnt;
  logic [LIFE_W-1:0] lives1_q, lives2_q;
  logic              hit1_q, hit2_q, block1_q, block2_q;
  logic              game_over_q;
  logic [1:0]        winner_q;

  logic [RW-1:0]     hw1, hw2, front1, front2, p2_ext;
  logic              reach1, reach2;
  logic              att1, att2;
  logic              res1, res2;
  logic              res1_blocked, res2_blocked;
  logic              dmg1, dmg2;
  logic [LIFE_W-1:0] lives1_n, lives2_n;
  logic              stun1, stun2;

  assign stun1 = (stun1_cnt != '0);
  assign stun2 = (stun2_cnt != '0);

  // Both reach tests measure against p2's left edge: p1 faces right, p2 faces left.
  always_comb begin
    hw1 = '0;
    if (bus.dir_attacking1)  hw1 = RW'(HIT_W_DIR);
    else if (bus.attacking1) hw1 = RW'(HIT_W_BASIC);
    hw2 = '0;
    if (bus.dir_attacking2)  hw2 = RW'(HIT_W_DIR);
    else if (bus.attacking2) hw2 = RW'(HIT_W_BASIC);
    p2_ext = RW'(bus.p2_x);
    front1 = RW'(bus.p1_x) + RW'(SPRITE_W) + hw1;
    front2 = RW'(bus.p1_x) + RW'(SPRITE_W) + hw2;
    reach1 = (front1 > p2_ext);
    reach2 = (front2 > p2_ext);
  end

  // Stun flags come from the registered counters, so a player struck this cycle still resolves.
  always_comb begin
    att1 = (bus.state_1 == ST_ACT) && !stun1;
    att2 = (bus.state_2 == ST_ACT) && !stun2;
    res1 = att1 && !latch1 && reach1 && (phase == PLAY);
    res2 = att2 && !latch2 && reach2 && (phase == PLAY);
    res1_blocked = res1 && (BLOCK_EN != 0) && (bus.state_2 == ST_BWD);
    res2_blocked = res2 && (BLOCK_EN != 0) && (bus.state_1 == ST_BWD);
    dmg1 = res1 && !res1_blocked;
    dmg2 = res2 && !res2_blocked;
    lives2_n = (dmg1 && lives2_q != '0) ? lives2_q - LIFE_W'(1) : lives2_q;
    lives1_n = (dmg2 && lives1_q != '0) ? lives1_q - LIFE_W'(1) : lives1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= PLAY;
      latch1      <= 1'b0;
      latch2      <= 1'b0;
      stun1_cnt   <= '0;
      stun2_cnt   <= '0;
      lives1_q    <= LIVES_INIT;
      lives2_q    <= LIVES_INIT;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      block1_q    <= 1'b0;
      block2_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      hit1_q   <= dmg1;
      hit2_q   <= dmg2;
      block2_q <= res1_blocked;
      block1_q <= res2_blocked;

      latch1 <= (bus.state_1 == ST_ACT) && (latch1 || res1);
      latch2 <= (bus.state_2 == ST_ACT) && (latch2 || res2);

      // A fresh hit reloads the victim's stun; counters keep draining after game over.
      if (dmg2)       stun1_cnt <= STUN_LOAD;
      else if (stun1) stun1_cnt <= stun1_cnt - STUN_W'(1);
      if (dmg1)       stun2_cnt <= STUN_LOAD;
      else if (stun2) stun2_cnt <= stun2_cnt - STUN_W'(1);

      lives1_q <= lives1_n;
      lives2_q <= lives2_n;

      case (phase)
        PLAY: begin
          if (lives1_n == '0 || lives2_n == '0) begin
            phase       <= OVER;
            game_over_q <= 1'b1;
            winner_q    <= {lives1_n == '0, lives2_n == '0};
          end
        end
        default: begin
          phase       <= OVER;
          game_over_q <= 1'b1;
        end
      endcase
    end
  end

  generate
    for (genvar k = 0; k < LIVES; k++) begin : g_leds
      assign bus.life_leds1[k] = (lives1_q > LIFE_W'(k));
      assign bus.life_leds2[k] = (lives2_q > LIFE_W'(k));
    end
  endgenerate

  assign bus.hit1_pulse   = hit1_q;
  assign bus.hit2_pulse   = hit2_q;
  assign bus.block1_pulse = block1_q;
  assign bus.block2_pulse = block2_q;
  assign bus.stun1_flag   = stun1;
  assign bus.stun2_flag   = stun2;
  assign bus.lives1       = lives1_q;
  assign bus.lives2       = lives2_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;

endmodule

// File: doc/hit_resolver.md
Name: hit_resolver

Overview:
Parametrised successor to the two-player hit detector. It sits between the two player FSMs and the renderer/LED drivers. Each clock it resolves attacks from both players against the opponent's position, with one hit per attack, blocking, timed stun, saturating life counters, a game-over latch and thermometer life LEDs. All geometry, timing and life counts are parameters.

Parameters:
X_W, 10, width of player x positions
ST_W, 4, width of player state codes
SPRITE_W, 64, player sprite width in pixels
HIT_W_BASIC, 32, reach beyond sprite for a basic attack
HIT_W_DIR, 20, reach beyond sprite for a directional attack
S_ATTACK_ACT, 6, state code of the active attack frame
S_MOVE_BWD, 2, state code treated as blocking
LIVES, 3, starting lives per player (>=1)
LIFE_W, 2, life counter width (must satisfy 2^LIFE_W > LIVES)
STUN_CYCLES, 30, stun duration in clk cycles (>=1)
BLOCK_EN, 1, 1 = backward-moving defender blocks; 0 = no blocking

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
state_1  in  ST_W  player-1 FSM state
state_2  in  ST_W  player-2 FSM state
p1_x  in  X_W  player-1 left edge (p1 faces right)
p2_x  in  X_W  player-2 left edge (p2 faces left)
attacking1  in  1  p1 attack is basic
dir_attacking1  in  1  p1 attack is directional (priority over basic)
attacking2  in  1  p2 attack is basic
dir_attacking2  in  1  p2 attack is directional (priority over basic)
hit1_pulse  out  1  1-cycle: p1 landed a damaging hit
hit2_pulse  out  1  1-cycle: p2 landed a damaging hit
block1_pulse  out  1  1-cycle: p1 blocked p2's hit
block2_pulse  out  1  1-cycle: p2 blocked p1's hit
stun1_flag  out  1  p1 stunned
stun2_flag  out  1  p2 stunned
lives1  out  LIFE_W  p1 remaining lives
lives2  out  LIFE_W  p2 remaining lives
life_leds1  out  LIVES  p1 thermometer, bit k = (lives1 > k)
life_leds2  out  LIVES  p2 thermometer
game_over  out  1  a player reached 0 lives
winner  out  2  00 none, 01 p1, 10 p2, 11 draw

Behaviour:
- Reset (async) values:
  - lives = LIVES, so LEDs are all ones.
  - Pulses, stun flags, game_over and winner = 0.
  - Per-player hit latches cleared.
  - FSM in PLAY.
- Reach widths:
  - hw1 = HIT_W_DIR if dir_attacking1, else HIT_W_BASIC if attacking1, else 0. hw2 is the same for p2.
- Reach tests:
  - Computed in X_W+2 bits, zero-extended; no wrap.
  - reach1 = (p1_x + SPRITE_W + hw1 > p2_x).
  - reach2 = (p1_x + SPRITE_W + hw2 > p2_x). This is the subtraction-free form of p2_x - hw2 - SPRITE_W < p1_x.
- Attack valid:
  - attN = (state_N == S_ATTACK_ACT) and not stunN_flag.
- Hit latch:
  - latchN is set when player N's attack resolves, whether it hits or is blocked.
  - latchN clears on any cycle with state_N != S_ATTACK_ACT.
  - Only one resolution per attack frame sequence.
- Resolution for p1 (p2 symmetric):
  - Resolves when att1, not latch1, reach1 and FSM is PLAY.
  - If BLOCK_EN and state_2 == S_MOVE_BWD: block2_pulse = 1 and lives unchanged.
  - Otherwise: hit1_pulse = 1, lives2 decrements (saturating at 0), and stun2 loads STUN_CYCLES.
- Simultaneous:
  - Both players may resolve in the same cycle; both take effect (trade).
  - A player who is struck and stunned in cycle t still completes its own resolution in t.
- Stun:
  - Down-counter per player; stunN_flag = (count != 0).
  - A new hit while stunned reloads the counter to STUN_CYCLES.
- Outputs registered:
  - Pulses, lives and LEDs update on the clock edge after the resolving cycle (1-cycle latency).
- FSM:
  - PLAY -> OVER when an updated life counter equals 0.
  - winner on entry: 01 if only lives2 == 0, 10 if only lives1 == 0, 11 if both.
  - OVER is absorbing until reset: no pulses, lives frozen, stun counters continue to drain, game_over = 1.
- Reset mid-attack:
  - Clears everything.
  - An attack still active after reset resolves fresh.

Test Plan:
1. Basic hit:
   - Stimulus: p1_x=100, p2_x=190, attacking1, state_1=6 for 5 cycles.
   - Expect: reach 196>190; exactly one hit1_pulse; lives2 3->2; life_leds2=011; stun2 high 30 cycles.
2. Directional miss/hit boundary:
   - Stimulus: dir_attacking1, p1_x=100; p2_x=184 then p2_x=183.
   - Expect: 184 is no hit (184>184 false); 183 gives a hit.
3. Block:
   - Stimulus: state_2=2, p2 in reach, p1 attacks.
   - Expect: block2_pulse once; lives2 stays 3; no stun. Repeat with BLOCK_EN=0 and expect a normal hit.
4. Trade:
   - Stimulus: both players attack in reach in the same cycle.
   - Expect: hit1_pulse and hit2_pulse together; both lives 3->2; both stunned.
5. Game over:
   - Stimulus: three separate p1 attack sequences.
   - Expect: lives2 reaches 0 and saturates; game_over=1; winner=01; a fourth attack gives no pulse.
   - Also: a simultaneous final trade from 1/1 gives winner=11.
6. Stun lockout and async reset:
   - Stimulus: a stunned p2 enters state 6 in reach.
   - Expect: no hit2_pulse.
   - Then: assert reset mid-stun. Expect immediate stun clear, lives=3, LEDs=111.
